csr_abstract_cmd: RTL and testbench

Debug-module abstract-command engine that acts as the initiator toward the core's CSR file, whose port it shares with the pipeline. It accepts RISC-V "Access Register" commands targeting CSRs (regno 0x0000-0x0FFF) and arbitrates for the CSR port with a req/gnt handshake. It then issues one CSRRW (write) or CSRRS-with-x0 (read) access with the debug flag set, and reports results through data0 and a sticky cmderr field.

---
 rtl/csr_abstract_cmd.sv | 166 ++++++++++++++++
 tb/tb_csr_abstract_cmd.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_abstract_cmd.sv
// Debug-module abstract-command engine for CSR access.
// Arbitrates for the shared CSR port and runs one read or write per command.
module csr_abstract_cmd #(
    parameter int XLEN     = 32,
    parameter int CSR_ALEN = 12,
    parameter int RFLEN    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_write,
    input  logic [31:0]      cmd,
    input  logic [XLEN-1:0]  data0_in,
    output logic             data0_we,
    output logic [XLEN-1:0]  data0_wdata,
    input  logic [2:0]       cmderr_clear,
    input  logic             halted,
    output logic             busy,
    output logic [2:0]       cmderr,
    output logic             csr_req,
    input  logic             csr_gnt,
    output logic [XLEN-1:0]  csr_addr,
    output logic [XLEN-1:0]  csr_reg_in,
    output logic [XLEN-1:0]  csr_imm_in,
    output logic [RFLEN-1:0] csr_rs,
    output logic [2:0]       csr_f3,
    output logic             csr_write,
    output logic             csr_debug,
    input  logic [XLEN-1:0]  csr_reg_out,
    input  logic             csr_illegal
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, DONE} state_t;

    state_t              state;
    logic                wr_q;
    logic [CSR_ALEN-1:0] regno_q;
    logic                bad_cmd;
    logic                err_set;
    logic [2:0]          err_code;
    logic                unused_cmd;

    assign unused_cmd = cmd[23];
    assign csr_imm_in = '0;

    assign bad_cmd = (cmd[31:24] != 8'd0) || (cmd[22:20] != 3'd2) ||
                     cmd[19] || cmd[18] ||
                     (cmd[17] && (cmd[15:0] > 16'h0FFF));

    // Only the first error after a clear is recorded.
    always_comb begin
        err_set  = 1'b0;
        err_code = 3'd0;
        if (cmderr == 3'd0) begin
            if (cmd_write && state != IDLE) begin
                err_set  = 1'b1;
                err_code = 3'd1;
            end else begin
                unique case (1'b1)
                    (state == IDLE): begin
                        if (cmd_write && bad_cmd) begin
                            err_set  = 1'b1;
                            err_code = 3'd2;
                        end else if (cmd_write && !halted) begin
                            err_set  = 1'b1;
                            err_code = 3'd4;
                        end
                    end
                    (state == REQ): begin
                        if (!halted) begin
                            err_set  = 1'b1;
                            err_code = 3'd4;
                        end
                    end
                    (state == ACCESS): begin
                        if (csr_illegal) begin
                            err_set  = 1'b1;
                            err_code = 3'd3;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmderr <= 3'd0;
        end else if (err_set) begin
            cmderr <= err_code;
        end else begin
            cmderr <= cmderr & ~cmderr_clear;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            regno_q     <= '0;
            busy        <= 1'b0;
            data0_we    <= 1'b0;
            data0_wdata <= '0;
            csr_req     <= 1'b0;
            csr_addr    <= '0;
            csr_reg_in  <= '0;
            csr_rs      <= '0;
            csr_f3      <= 3'd0;
            csr_write   <= 1'b0;
            csr_debug   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_write && cmderr == 3'd0 &&
                        !bad_cmd && halted) begin
                        busy <= 1'b1;
                        if (cmd[17]) begin
                            state   <= REQ;
                            csr_req <= 1'b1;
                            wr_q    <= cmd[16];
                            regno_q <= cmd[CSR_ALEN-1:0];
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    // Losing halt aborts even if the grant arrives now.
                    if (!halted) begin
                        state   <= DONE;
                        csr_req <= 1'b0;
                    end else if (csr_gnt) begin
                        state      <= ACCESS;
                        csr_write  <= 1'b1;
                        csr_debug  <= 1'b1;
                        csr_addr   <= {{(XLEN-CSR_ALEN){1'b0}}, regno_q};
                        csr_f3     <= wr_q ? 3'b001 : 3'b010;
                        csr_reg_in <= wr_q ? data0_in : '0;
                        csr_rs     <= wr_q ? RFLEN'(1) : '0;
                    end
                end
                ACCESS: begin
                    state      <= DONE;
                    csr_req    <= 1'b0;
                    csr_write  <= 1'b0;
                    csr_debug  <= 1'b0;
                    csr_addr   <= '0;
                    csr_f3     <= 3'd0;
                    csr_reg_in <= '0;
                    csr_rs     <= '0;
                    if (!wr_q && !csr_illegal) begin
                        data0_we    <= 1'b1;
                        data0_wdata <= csr_reg_out;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    data0_we <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_abstract_cmd.sv
// Self-checking bench for csr_abstract_cmd.
// Vector table plus hand-written arbitration, error and reset sequences.
module tb_csr_abstract_cmd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_write;
    logic [31:0] cmd;
    logic [31:0] data0_in;
    logic        data0_we;
    logic [31:0] data0_wdata;
    logic [2:0]  cmderr_clear;
    logic        halted;
    logic        busy;
    logic [2:0]  cmderr;
    logic        csr_req;
    logic        csr_gnt;
    logic [31:0] csr_addr;
    logic [31:0] csr_reg_in;
    logic [31:0] csr_imm_in;
    logic [4:0]  csr_rs;
    logic [2:0]  csr_f3;
    logic        csr_write;
    logic        csr_debug;
    logic [31:0] csr_reg_out;
    logic        csr_illegal;

    csr_abstract_cmd dut (
        .clk(clk), .rst_n(rst_n), .cmd_write(cmd_write), .cmd(cmd),
        .data0_in(data0_in), .data0_we(data0_we),
        .data0_wdata(data0_wdata), .cmderr_clear(cmderr_clear),
        .halted(halted), .busy(busy), .cmderr(cmderr),
        .csr_req(csr_req), .csr_gnt(csr_gnt), .csr_addr(csr_addr),
        .csr_reg_in(csr_reg_in), .csr_imm_in(csr_imm_in),
        .csr_rs(csr_rs), .csr_f3(csr_f3), .csr_write(csr_write),
        .csr_debug(csr_debug), .csr_reg_out(csr_reg_out),
        .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] rin;
        logic [4:0]  rs;
    } acc_t;

    typedef struct {
        logic [31:0] cmd;
        logic        halted;
        logic [31:0] d0;
        logic [31:0] rout;
        logic        ill;
        logic [2:0]  err;
        int          nbusy;
        logic        acc;
    } vec_t;

    acc_t        exp_acc[$];
    logic [31:0] exp_rd[$];
    acc_t        got;
    logic [31:0] got_rd;
    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        vecs[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] c);
        cmd       = c;
        cmd_write = 1'b1;
        step();
        cmd_write = 1'b0;
    endtask

    task automatic push_exp(input vec_t v);
        acc_t a;
        a.addr = {20'd0, v.cmd[11:0]};
        a.f3   = v.cmd[16] ? 3'b001 : 3'b010;
        a.rin  = v.cmd[16] ? v.d0 : 32'd0;
        a.rs   = v.cmd[16] ? 5'd1 : 5'd0;
        exp_acc.push_back(a);
        if (!v.cmd[16] && !v.ill)
            exp_rd.push_back(v.rout);
    endtask

    task automatic run_vec(input vec_t v, input bit clr, input string nm);
        int n;
        halted      = v.halted;
        data0_in    = v.d0;
        csr_reg_out = v.rout;
        csr_illegal = v.ill;
        csr_gnt     = 1'b1;
        if (v.acc)
            push_exp(v);
        issue(v.cmd);
        n = 0;
        while (busy && n < 20) begin
            n++;
            step();
        end
        check({nm, "_busy_cycles"}, n, v.nbusy);
        check({nm, "_cmderr"}, {29'd0, cmderr}, {29'd0, v.err});
        csr_illegal = 1'b0;
        halted      = 1'b1;
        if (clr) begin
            cmderr_clear = 3'b111;
            step();
            cmderr_clear = 3'b000;
            check({nm, "_cleared"}, {29'd0, cmderr}, 32'd0);
        end
    endtask

    // Scoreboard: compare each CSR access and data0 load as it appears.
    always @(negedge clk) begin
        if (csr_write) begin
            if (exp_acc.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_csr_write: got addr %h expected none",
                         csr_addr);
            end else begin
                got = exp_acc.pop_front();
                check("acc_addr", csr_addr, got.addr);
                check("acc_f3", {29'd0, csr_f3}, {29'd0, got.f3});
                check("acc_reg_in", csr_reg_in, got.rin);
                check("acc_rs", {27'd0, csr_rs}, {27'd0, got.rs});
                check("acc_req_debug", {30'd0, csr_req, csr_debug}, 32'd3);
                check("acc_imm", csr_imm_in, 32'd0);
            end
        end
        if (data0_we) begin
            if (exp_rd.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_data0_we: got %h expected none",
                         data0_wdata);
            end else begin
                got_rd = exp_rd.pop_front();
                check("data0_wdata", data0_wdata, got_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h0023_07B2, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 3'd0, 3, 1'b1};
        vecs[1]  = '{32'h0022_0300, 1'b1, 32'h0, 32'h0000_1800, 1'b0, 3'd0, 3, 1'b1};
        vecs[2]  = '{32'h0023_0C00, 1'b1, 32'h0000_A5A5, 32'h0, 1'b1, 3'd3, 3, 1'b1};
        vecs[3]  = '{32'h0032_0300, 1'b1, 32'h0, 32'h0, 1'b0, 3'd2, 0, 1'b0};
        vecs[4]  = '{32'h0022_0300, 1'b0, 32'h0, 32'h0, 1'b0, 3'd4, 0, 1'b0};
        vecs[5]  = '{32'h0020_0300, 1'b1, 32'h0, 32'h0, 1'b0, 3'd0, 1, 1'b0};
        vecs[6]  = '{32'h0022_1000, 1'b1, 32'h0, 32'h0, 1'b0, 3'd2, 0, 1'b0};
        vecs[7]  = '{32'h0122_0300, 1'b1, 32'h0, 32'h0, 1'b0, 3'd2, 0, 1'b0};
        vecs[8]  = '{32'h0026_0300, 1'b1, 32'h0, 32'h0, 1'b0, 3'd2, 0, 1'b0};
        vecs[9]  = '{32'h002A_0300, 1'b1, 32'h0, 32'h0, 1'b0, 3'd2, 0, 1'b0};
        vecs[10] = '{32'h0022_0F14, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, 3'd0, 3, 1'b1};

        rst_n        = 1'b0;
        cmd_write    = 1'b0;
        cmd          = 32'd0;
        data0_in     = 32'd0;
        cmderr_clear = 3'd0;
        halted       = 1'b1;
        csr_gnt      = 1'b0;
        csr_reg_out  = 32'd0;
        csr_illegal  = 1'b0;
        step();
        step();
        check("reset_outputs",
              {27'd0, busy, csr_req, csr_write, csr_debug, data0_we},
              32'd0);
        check("reset_cmderr", {29'd0, cmderr}, 32'd0);
        check("reset_addr", csr_addr, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // Sticky error blocks new commands until cleared.
        run_vec(vecs[2], 1'b0, "sticky");
        issue(32'h0022_0300);
        check("sticky_ignored_busy", {31'd0, busy}, 32'd0);
        check("sticky_kept", {29'd0, cmderr}, 32'd3);
        cmderr_clear = 3'b111;
        step();
        cmderr_clear = 3'b000;
        check("sticky_cleared", {29'd0, cmderr}, 32'd0);

        // Second command while in REQ flags busy error; first completes.
        begin
            vec_t v;
            int   n;
            v = '{32'h0022_0300, 1'b1, 32'h0, 32'h0000_0055, 1'b0, 3'd1, 0, 1'b1};
            csr_gnt     = 1'b0;
            csr_reg_out = v.rout;
            push_exp(v);
            issue(v.cmd);
            issue(32'h0023_07B2);
            check("busy_err", {29'd0, cmderr}, 32'd1);
            csr_gnt = 1'b1;
            n = 0;
            while (busy && n < 20) begin
                n++;
                step();
            end
            check("busy_err_completes", n, 3);
            check("busy_err_kept", {29'd0, cmderr}, 32'd1);
            cmderr_clear = 3'b111;
            step();
            cmderr_clear = 3'b000;
        end

        // Grant withheld, then halt lost while requesting.
        csr_gnt = 1'b0;
        issue(32'h0022_0300);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("arb_req%0d", i),
                  {30'd0, csr_req, csr_write}, 32'd2);
            step();
        end
        halted = 1'b0;
        step();
        check("arb_req_fall", {31'd0, csr_req}, 32'd0);
        check("arb_halt_err", {29'd0, cmderr}, 32'd4);
        check("arb_busy_done", {31'd0, busy}, 32'd1);
        step();
        check("arb_busy_low", {31'd0, busy}, 32'd0);
        halted       = 1'b1;
        cmderr_clear = 3'b111;
        step();
        cmderr_clear = 3'b000;

        // Async reset in the middle of an ACCESS cycle.
        csr_gnt     = 1'b1;
        csr_reg_out = 32'h0000_7777;
        issue(32'h0022_0300);
        step();
        check("rst_in_access", {31'd0, csr_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              {27'd0, busy, csr_req, csr_write, csr_debug, data0_we},
              32'd0);
        check("rst_async_addr", csr_addr | csr_reg_in, 32'd0);
        step();
        check("rst_no_data0_we", {31'd0, data0_we}, 32'd0);
        rst_n = 1'b1;
        step();
        run_vec(vecs[1], 1'b1, "post_reset_read");

        step();
        step();
        check("acc_queue_empty", exp_acc.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
